// File: rtl/prog_tt_pkg.sv
// Shared types and helpers for the programmable truth-table block.
package prog_tt_pkg;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } loader_state_e;

  // Row 0 lives in the table MSB, so row idx maps to bit (2**n_in - 1 - idx).
  function automatic int tt_bit_pos(input int idx, input int n_in);
    return (1 << n_in) - 1 - idx;
  endfunction

endpackage

// File: rtl/prog_tt_loader.sv
// Serial truth-table loader: collects 2**N_IN bits MSB first into a shadow
// register and signals a one-cycle commit once the last bit has arrived.
module prog_tt_loader
  import prog_tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_bit,
  input  logic                 cfg_bit_valid,
  output logic [2**N_IN-1:0]   shadow,
  output logic                 cfg_busy,
  output logic                 cfg_done
);

  localparam int W  = 2**N_IN;
  localparam int CW = $clog2(W) + 1;

  loader_state_e  state;
  logic [CW-1:0]  bit_cnt;

  // A start in LOAD restarts from scratch; a start in COMMIT is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state   <= LOAD;
            bit_cnt <= '0;
            shadow  <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            bit_cnt <= '0;
            shadow  <= '0;
          end else if (cfg_bit_valid) begin
            shadow  <= {shadow[W-2:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(W - 1)) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cfg_busy = (state != IDLE);
  assign cfg_done = (state == COMMIT);

endmodule

// File: rtl/prog_truth_table.sv
// Programmable N_IN-input truth table: two-stage evaluation pipeline reading
// an active table that is swapped atomically by the serial loader.
module prog_truth_table
  import prog_tt_pkg::*;
#(
  parameter int                N_IN       = 3,
  parameter logic [2**N_IN-1:0] TT_DEFAULT = 8'hCE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            in_valid,
  output logic            out,
  output logic            out_valid,
  input  logic            cfg_start,
  input  logic            cfg_bit,
  input  logic            cfg_bit_valid,
  output logic            cfg_busy,
  output logic            cfg_done
);

  localparam int W = 2**N_IN;

  logic [W-1:0]    active_tt;
  logic [W-1:0]    shadow;
  logic [N_IN-1:0] s1_in;
  logic            s1_valid;
  logic [N_IN-1:0] bit_pos;

  prog_tt_loader #(.N_IN(N_IN)) u_loader (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_bit       (cfg_bit),
    .cfg_bit_valid (cfg_bit_valid),
    .shadow        (shadow),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done)
  );

  // The swap lands on the edge ending COMMIT, so that cycle's lookup still sees the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_tt <= TT_DEFAULT;
    end else if (cfg_done) begin
      active_tt <= shadow;
    end
  end

  assign bit_pos = N_IN'(tt_bit_pos(int'(s1_in), N_IN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in     <= '0;
      s1_valid  <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_in     <= in;
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= active_tt[bit_pos];
      end
    end
  end

endmodule

// File: doc/prog_truth_table.md
PROG_TRUTH_TABLE -- requirements
Module: prog_truth_table

Interface
REQ-001 The block SHALL have these parameters:
- N_IN, default 3, number of logic inputs, legal range 1..6.
- TT_DEFAULT, default 8'hCE, reset truth table of width 2**N_IN.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in  input  N_IN  logic inputs; in[N_IN-1] is in1, the MSB.
- in_valid  input  1  qualifies in.
- out  output  1  evaluated function value.
- out_valid  output  1  qualifies out.
- cfg_start  input  1  one-cycle pulse that begins a truth-table load.
- cfg_bit  input  1  serial truth-table bit.
- cfg_bit_valid  input  1  qualifies cfg_bit.
- cfg_busy  output  1  high while a load is in progress.
- cfg_done  output  1  one-cycle pulse when a new table is committed.

Function
REQ-003 Table indexing SHALL be: idx = unsigned(in); out = table[2**N_IN-1-idx].
- Row 000 is therefore the table MSB.
- With N_IN=3, 0xCE gives rows 000..111 = 1,1,0,0,1,1,1,0.
REQ-004 Evaluation SHALL be a 2-stage pipeline:
- Stage 1 registers in and in_valid.
- Stage 2 registers the lookup result into out and out_valid.
- Latency is exactly 2 cycles, with one result per cycle and no stalls.
REQ-005 While out_valid is 0, out SHALL hold its last value.
REQ-006 The loader SHALL be an FSM with states IDLE, LOAD and COMMIT.
REQ-007 IDLE SHALL behave as follows:
- cfg_start moves the FSM to LOAD and clears the bit counter.
- cfg_bit_valid in IDLE is ignored.
REQ-008 LOAD SHALL behave as follows:
- Each cfg_bit_valid shifts cfg_bit into a shadow register, MSB first, and increments the counter.
- On the 2**N_IN-th accepted bit the FSM moves to COMMIT.
- Gaps between valid bits are allowed with no timeout.
REQ-009 COMMIT SHALL last exactly one cycle:
- The shadow register is copied atomically into the active table.
- cfg_done is pulsed.
- The FSM returns to IDLE.
REQ-010 cfg_busy SHALL be 1 in LOAD and COMMIT and 0 in IDLE.
REQ-011 cfg_start asserted in LOAD SHALL restart the load: the counter clears, the shadow is discarded, and the FSM stays in LOAD.
REQ-012 cfg_start in COMMIT SHALL be ignored.
REQ-013 Evaluation SHALL use the active table only; a partial load never affects out.
REQ-014 In the COMMIT cycle, the stage-2 lookup SHALL use the old table; the new table applies from the next cycle.
REQ-015 The bit counter SHALL be $clog2(2**N_IN)+1 bits wide and never wraps, because COMMIT is reached at exactly 2**N_IN bits.

Reset
REQ-016 While rst=1, the block SHALL asynchronously force:
- active table = TT_DEFAULT, shadow = 0, FSM = IDLE, counter = 0;
- stage registers = 0, out = 0, out_valid = 0, cfg_busy = 0, cfg_done = 0.
REQ-017 Reset mid-load SHALL abandon the load; the table reverts to TT_DEFAULT, not the previously committed table.
REQ-018 The first accepted in_valid after reset deassertion SHALL produce out_valid exactly 2 cycles later.

Structure
REQ-019 Package prog_tt_pkg SHALL hold:
- the loader state enum (IDLE, LOAD, COMMIT);
- the N_IN legality limits;
- a function mapping idx to table bit position.
REQ-020 The loader FSM, counter and shadow register SHALL be one sub-module, prog_tt_loader, instantiated once; the evaluation pipeline stays in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Default table: after reset, in=010 with in_valid -> out=0 at +2 cycles; in=110 -> out=1; all 8 rows match 0xCE.
- Load: cfg_start, then 8 bits of 0x96 MSB first -> cfg_done one cycle after the 8th bit; in=001 -> out=0, in=000 -> out=1.
- Commit overlap: in_valid every cycle through COMMIT -> results up to and including the COMMIT-cycle lookup use 0xCE, later results use 0x96.
- Restart: cfg_start, 3 bits, cfg_start again, 8 bits of 0x01 -> table = 0x01; only in=111 gives out=1.
- Reset mid-load: after 0x96 is committed, start a load, assert rst after 4 bits -> table = 0xCE, cfg_busy=0, out_valid=0.
- Parameter sweep: N_IN=1 with TT_DEFAULT=2'b10 -> in=0 gives out=1, in=1 gives out=0; N_IN=6 load takes 64 bits.
